// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command sequencer.
//   - opcode_t and the engine opcode values (OP_WRITE .. OP_MIRROR_Y, OP_LAST)
//   - seq_state_e: sequencer FSM state encoding
//   - op_is_reserved(): opcodes above OP_LAST are outside the engine's set
package lcd_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_WRITE       = 4'd0;
    localparam opcode_t OP_INVERT      = 4'd1;
    localparam opcode_t OP_SHIFT_UP    = 4'd2;
    localparam opcode_t OP_SHIFT_DOWN  = 4'd3;
    localparam opcode_t OP_SHIFT_LEFT  = 4'd4;
    localparam opcode_t OP_SHIFT_RIGHT = 4'd5;
    localparam opcode_t OP_ZOOM_IN     = 4'd6;
    localparam opcode_t OP_ZOOM_OUT    = 4'd7;
    localparam opcode_t OP_ROT_LEFT    = 4'd8;
    localparam opcode_t OP_ROT_RIGHT   = 4'd9;
    localparam opcode_t OP_MIRROR_X    = 4'd10;
    localparam opcode_t OP_MIRROR_Y    = 4'd11;
    localparam opcode_t OP_LAST        = OP_MIRROR_Y;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssue    = 3'd1,
        StHold     = 3'd2,
        StWaitDone = 3'd3,
        StFin      = 3'd4
    } seq_state_e;

    function automatic logic op_is_reserved(opcode_t op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// Host and engine signal bundle for lcd_cmd_sequencer.
//   slave  : sequencer side (consumes in_cmd/in_valid/lcd_busy/lcd_done, drives the rest)
//   master : host/engine side
// Signals: in_cmd, in_valid, in_ready, lcd_cmd, lcd_cmd_valid, lcd_busy, lcd_done,
//          seq_done, fifo_level, issue_cnt, and drop_cnt when LCD_SEQ_FILTER_EN is defined.
interface lcd_cmd_sequencer_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
);
    import lcd_pkg::*;

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    opcode_t            in_cmd;
    logic               in_valid;
    logic               in_ready;
    opcode_t            lcd_cmd;
    logic               lcd_cmd_valid;
    logic               lcd_busy;
    logic               lcd_done;
    logic               seq_done;
    logic [LVL_W-1:0]   fifo_level;
    logic [CNT_W-1:0]   issue_cnt;
`ifdef LCD_SEQ_FILTER_EN
    logic [CNT_W-1:0]   drop_cnt;

    modport slave (
        input  in_cmd, in_valid, lcd_busy, lcd_done,
        output in_ready, lcd_cmd, lcd_cmd_valid, seq_done, fifo_level, issue_cnt, drop_cnt
    );

    modport master (
        output in_cmd, in_valid, lcd_busy, lcd_done,
        input  in_ready, lcd_cmd, lcd_cmd_valid, seq_done, fifo_level, issue_cnt, drop_cnt
    );
`else
    modport slave (
        input  in_cmd, in_valid, lcd_busy, lcd_done,
        output in_ready, lcd_cmd, lcd_cmd_valid, seq_done, fifo_level, issue_cnt
    );

    modport master (
        output in_cmd, in_valid, lcd_busy, lcd_done,
        input  in_ready, lcd_cmd, lcd_cmd_valid, seq_done, fifo_level, issue_cnt
    );
`endif

endinterface

// File: rtl/lcd_cmd_fifo.sv
// DEPTH x 4 synchronous opcode FIFO (DEPTH a power of 2, >= 2).
// Ports: clk, reset (sync, active-low), push, pop, din, dout (head, combinational read),
//        full, empty, level (occupancy, $clog2(DEPTH)+1 bits).
// Pointers wrap naturally; full/empty are derived from the occupancy counter.
// A push while full or a pop while empty is ignored.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  opcode_t                    din,
    output opcode_t                    dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    opcode_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Command scheduler in front of the LCD image-processing engine.
// Host opcodes are queued in lcd_cmd_fifo and issued one at a time while the engine is
// not busy; lcd_cmd_valid pulses for one cycle and lcd_cmd is held afterwards. Once a
// Write (opcode 0) is accepted no further opcodes are taken; after it is issued the
// sequencer waits for lcd_done, raises seq_done and parks in StFin until reset.
// Ports: clk, reset (sync, active-low), bus (lcd_cmd_sequencer_if.slave).
// Optional: define LCD_SEQ_FILTER_EN to drop opcodes 12-15 at the FIFO head (counted in
// bus.drop_cnt) instead of issuing them.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    lcd_cmd_sequencer_if.slave  bus
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    seq_state_e         state_q, state_d;
    opcode_t            lcd_cmd_q, lcd_cmd_d;
    logic               lcd_cmd_valid_q, lcd_cmd_valid_d;
    logic               seq_done_q, seq_done_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic               write_queued_q, write_queued_d;

    opcode_t            fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic               in_ready;
    logic               push;
    logic               pop;
    logic               head_drop;
    logic               issue_go;

    assign in_ready = !fifo_full && !write_queued_q && (state_q != StFin);
    assign push     = bus.in_valid && in_ready;

`ifdef LCD_SEQ_FILTER_EN
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    // Reserved opcodes are discarded from the head without waiting for the engine.
    assign head_drop = (state_q == StIdle) && !fifo_empty && op_is_reserved(fifo_dout);
`else
    assign head_drop = 1'b0;
`endif

    assign issue_go = (state_q == StIdle) && !fifo_empty && !head_drop && !bus.lcd_busy;

    lcd_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (bus.in_cmd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (issue_go) state_d = StIssue;
            StIssue:    state_d = (lcd_cmd_q == OP_WRITE) ? StWaitDone : StHold;
            StHold:     state_d = StIdle;
            StWaitDone: if (bus.lcd_done) state_d = StFin;
            StFin:      state_d = StFin;
            default:    state_d = StIdle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        lcd_cmd_d       = lcd_cmd_q;
        lcd_cmd_valid_d = 1'b0;
        seq_done_d      = seq_done_q;
        issue_cnt_d     = issue_cnt_q;
        pop             = 1'b0;
        write_queued_d  = write_queued_q || (push && (bus.in_cmd == OP_WRITE));
`ifdef LCD_SEQ_FILTER_EN
        drop_cnt_d      = drop_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (issue_go) begin
                    lcd_cmd_d       = fifo_dout;
                    lcd_cmd_valid_d = 1'b1;
                    pop             = 1'b1;
                end else if (head_drop) begin
                    pop = 1'b1;
`ifdef LCD_SEQ_FILTER_EN
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            StIssue: begin
                if (issue_cnt_q != '1) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
            end
            StWaitDone: begin
                if (bus.lcd_done) begin
                    seq_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lcd_cmd_q       <= OP_WRITE;
            lcd_cmd_valid_q <= 1'b0;
            seq_done_q      <= 1'b0;
            issue_cnt_q     <= '0;
            write_queued_q  <= 1'b0;
        end else begin
            lcd_cmd_q       <= lcd_cmd_d;
            lcd_cmd_valid_q <= lcd_cmd_valid_d;
            seq_done_q      <= seq_done_d;
            issue_cnt_q     <= issue_cnt_d;
            write_queued_q  <= write_queued_d;
        end
    end

`ifdef LCD_SEQ_FILTER_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

    assign bus.in_ready      = in_ready;
    assign bus.lcd_cmd       = lcd_cmd_q;
    assign bus.lcd_cmd_valid = lcd_cmd_valid_q;
    assign bus.seq_done      = seq_done_q;
    assign bus.fifo_level    = fifo_level;
    assign bus.issue_cnt     = issue_cnt_q;

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Command scheduler in front of the LCD image-processing engine, which executes 4-bit opcodes 0=Write through 11=MirrorY. A host pushes opcodes into a small FIFO through a valid/ready handshake. The sequencer issues each opcode to the engine only while the engine reports not-busy, and holds the opcode stable for the engine's execute cycle. After issuing Write (opcode 0) it stops accepting opcodes and reports completion once the engine asserts done.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2, minimum 2
CNT_W, 16, width of the issued-command counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low reset
in_cmd  input  4  opcode from the host
in_valid  input  1  host offers in_cmd
in_ready  output  1  sequencer accepts; a push happens when in_valid && in_ready
lcd_cmd  output  4  opcode to the engine
lcd_cmd_valid  output  1  issue strobe to the engine
lcd_busy  input  1  engine busy (image load, execute or write-back)
lcd_done  input  1  engine finished write-back
seq_done  output  1  sequence complete, sticky until reset
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy
issue_cnt  output  CNT_W  number of opcodes issued to the engine, saturating

Behaviour:
- Reset (reset==0 at a clk edge) takes priority at every point, including mid-issue and mid-wait. It clears:
  - state to IDLE, FIFO empty, write_queued=0
  - lcd_cmd=0, lcd_cmd_valid=0, seq_done=0, issue_cnt=0, fifo_level=0
- All outputs are registered except in_ready.
- in_ready = !full && !write_queued && state!=FIN.
- write_queued sets on a push of opcode 0 and stays set until reset.
- Push when FIFO is full: no handshake, and nothing is lost because in_ready=0.
- A simultaneous push and pop in the same cycle is allowed. Occupancy is unchanged.
- in_ready is not raised by a same-cycle pop; there is no bypass path.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. full/empty come from the occupancy counter.
- FSM states: IDLE, ISSUE, HOLD, WAIT_DONE, FIN.
  - IDLE: if FIFO non-empty and lcd_busy==0:
    - register lcd_cmd <= head and lcd_cmd_valid <= 1
    - pop the head
    - go to ISSUE
    - otherwise stay in IDLE
  - ISSUE (lcd_cmd_valid=1 for exactly this cycle; the engine samples here):
    - lcd_cmd_valid <= 0 and issue_cnt increments, saturating at all-ones
    - if lcd_cmd==0, go to WAIT_DONE; else go to HOLD
  - HOLD: lcd_cmd is held unchanged for the engine's execute cycle, then go to IDLE.
  - WAIT_DONE: lcd_cmd is held. On lcd_done==1, seq_done <= 1 and go to FIN.
  - FIN: terminal until reset. in_ready=0. Any residual FIFO contents are ignored and not issued.
- Throughput: at most one opcode every 3 cycles (IDLE -> ISSUE -> HOLD).
- Latency from a push into an empty FIFO with lcd_busy==0 to lcd_cmd_valid: 2 cycles (push edge, then the IDLE decision edge).
- After reset the engine loads its image with lcd_busy=1. The sequencer waits in IDLE and no issue occurs while lcd_busy==1.
- lcd_busy rising in the same cycle as an IDLE issue decision: no issue that cycle.
- lcd_cmd changes only on an IDLE->ISSUE transition.

Optional Feature:
LCD_SEQ_FILTER_EN
- Defined:
  - Opcodes 12-15 are dropped at the FIFO head in IDLE: popped without issue, without needing lcd_busy==0, and without incrementing issue_cnt.
  - Adds output drop_cnt [CNT_W-1:0], saturating, reset to 0.
- Undefined: every opcode is issued unchanged. There is no drop_cnt port.

Decomposition:
- Shared package lcd_pkg holds:
  - opcode localparams OP_WRITE=0 through OP_MIRROR_Y=11
  - sequencer state encodings
  - OP_LAST=11
- One sub-module: lcd_cmd_fifo, a parameterised DEPTH x 4 synchronous FIFO. Ports: push, pop, din, dout (head), full, empty, level; same clk and reset.
- The FSM, counters and filter stay in lcd_cmd_sequencer.

Test Plan:
- Reset; hold lcd_busy=1 for 70 cycles; push 5 (ShiftRight) -> no lcd_cmd_valid until lcd_busy=0. Then a single-cycle lcd_cmd_valid with lcd_cmd=5, and lcd_cmd stays 5 in the following cycle; issue_cnt=1.
- Push 1,2,7,8,0 back-to-back, engine model idle -> issues in order 1,2,7,8,0, spaced 3 cycles apart. in_ready drops after the 0 is accepted. Assert lcd_done -> seq_done=1 and the FSM stays in FIN.
- Push DEPTH=8 opcodes with lcd_busy=1 -> fifo_level=8 and in_ready=0. The 9th offer is not accepted. Release lcd_busy -> all 8 issue in order, and level returns to 0.
- Drive reset low mid-WAIT_DONE -> all outputs 0 on the next edge and the FIFO is empty. A new sequence 3,0 then completes normally.
- LCD_SEQ_FILTER_EN defined: push 13,6,0 -> only 6 and 0 are issued; drop_cnt=1, issue_cnt=2. Without the macro: 13 is issued and issue_cnt=3.
- Push and pop in the same cycle with fifo_level=3 -> level stays 3. Run more than 2*DEPTH pushes to exercise pointer wrap -> no lost or duplicated opcodes.
